fetch_controller: RTL

//  Sequences the IF stage against a variable-latency instruction memory.

---
 rtl/fetch_ctrl_pkg.sv | 23 ++
 rtl/fetch_timeout_counter.sv | 40 ++++
 rtl/register.sv | 20 ++
 rtl/fetch_controller.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the IF-stage fetch controller.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  localparam logic PC_SRC_SEQ = 1'b0;
  localparam logic PC_SRC_JMP = 1'b1;

  // Timeout counter width: enough to reach max_count, clamped to 8..16 bits.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    int unsigned w;
    w = $clog2(max_count + 1);
    if (w < 8)  w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Sticky imem timeout detector; only built when FETCH_TIMEOUT_EN is defined.
`ifdef FETCH_TIMEOUT_EN
module fetch_timeout_counter
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic wait_i,
  output logic timeout_o
);

  localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);

  logic [CW-1:0] count_q, count_d;
  logic          flag_q, flag_d;

  // Count consecutive waiting cycles (saturating); any non-wait cycle clears.
  always_comb begin
    count_d = '0;
    if (wait_i) count_d = (count_q == '1) ? count_q : count_q + 1'b1;
    flag_d = flag_q | (wait_i && (count_d == CW'(TIMEOUT_CYCLES)));
  end

  // Counter and sticky flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

  assign timeout_o = flag_q;

endmodule
`endif

// File: rtl/register.sv
// Generic load-enable register with synchronous clear and async reset.
module register #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage: clear wins over load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/fetch_controller.sv
// IF-stage sequencer for a variable-latency imem: owns the request
// handshake, PC/IF-ID enables, redirects, and a hold buffer for data that
// returns while ID is stalled. Define FETCH_TIMEOUT_EN for the sticky
// fetch_timeout flag (otherwise it is tied low).
module fetch_controller
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
`ifdef FETCH_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            imem_req,
  output logic [XLEN-1:0] inst,
  output logic            pc_en,
  output logic            PC_src,
  output logic [XLEN-1:0] jump_address,
  output logic            IF_ID_en,
  output logic            IF_flush,
  output logic            fetch_timeout
);

  state_t            state_q, state_d;
  logic [XLEN-1:0]   inst_buf_q, saved_addr_q;
  logic              buf_load, save_load;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and all combinational outputs.
  always_comb begin
    state_d      = state_q;
    imem_req     = 1'b0;
    inst         = '0;
    pc_en        = 1'b0;
    PC_src       = PC_SRC_SEQ;
    IF_ID_en     = 1'b0;
    IF_flush     = 1'b0;
    jump_address = redirect_valid ? redirect_addr : saved_addr_q;
    buf_load     = 1'b0;
    save_load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        jump_address = '0;
        state_d      = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        inst     = imem_rdata;
        if (redirect_valid) begin
          if (imem_ack) begin
            pc_en    = 1'b1;
            PC_src   = PC_SRC_JMP;
            IF_ID_en = 1'b1;
            IF_flush = 1'b1;
          end else begin
            save_load = 1'b1;
            state_d   = DISCARD;
          end
        end else if (imem_ack) begin
          if (stall) begin
            buf_load = 1'b1;
            state_d  = HOLD;
          end else begin
            pc_en    = 1'b1;
            IF_ID_en = 1'b1;
          end
        end
      end
      HOLD: begin
        inst = inst_buf_q;
        if (redirect_valid) begin
          pc_en    = 1'b1;
          PC_src   = PC_SRC_JMP;
          IF_ID_en = 1'b1;
          IF_flush = 1'b1;
          state_d  = FETCH;
        end else if (!stall) begin
          pc_en    = 1'b1;
          IF_ID_en = 1'b1;
          state_d  = FETCH;
        end
      end
      DISCARD: begin
        // Stale request stays up until acked; its data is never forwarded.
        imem_req = 1'b1;
        inst     = imem_rdata;
        if (redirect_valid) save_load = 1'b1;
        if (imem_ack) begin
          pc_en    = 1'b1;
          PC_src   = PC_SRC_JMP;
          IF_ID_en = 1'b1;
          IF_flush = 1'b1;
          state_d  = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  register #(.WIDTH(XLEN)) u_inst_buf (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .en  (buf_load),
    .d   (imem_rdata),
    .q   (inst_buf_q)
  );

  register #(.WIDTH(XLEN)) u_saved_addr (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .en  (save_load),
    .d   (redirect_addr),
    .q   (saved_addr_q)
  );

`ifdef FETCH_TIMEOUT_EN
  logic wait_cyc;
  assign wait_cyc = imem_req & ~imem_ack;

  fetch_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_i     (clk),
    .rst_i     (rst),
    .wait_i    (wait_cyc),
    .timeout_o (fetch_timeout)
  );
`else
  assign fetch_timeout = 1'b0;
`endif

endmodule
